sram_march_bist: RTL and testbench



---
 rtl/sram_march_bist.sv | 178 +++++++++++++++++
 tb/tb_sram_march_bist.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module : sram_march_bist
// Brief  : March C- BIST initiator for a single-port SRAM (1-cycle read latency)
// Rev    : 1.0
// ============================================================================
module sram_march_bist #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 1024,
    localparam int AW = $clog2(NUM_WORDS),
    localparam int BW = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [AW-1:0]         fail_addr_o,
    output logic [DATA_WIDTH-1:0] fail_data_o,
    output logic                  req_o,
    output logic                  we_o,
    output logic [AW-1:0]         addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [BW-1:0]         be_o,
    input  logic [DATA_WIDTH-1:0] rdata_i
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_M0    = 4'd1;
    localparam logic [3:0] S_M1    = 4'd2;
    localparam logic [3:0] S_M2    = 4'd3;
    localparam logic [3:0] S_M3    = 4'd4;
    localparam logic [3:0] S_M4    = 4'd5;
    localparam logic [3:0] S_M5    = 4'd6;
    localparam logic [3:0] S_CHECK = 4'd7;
    localparam logic [3:0] S_FIN   = 4'd8;

    localparam logic [AW-1:0]         C_LAST = AW'(NUM_WORDS - 1);
    localparam logic [DATA_WIDTH-1:0] C_ONES = {DATA_WIDTH{1'b1}};

    logic [3:0]            state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  ph_q, ph_d;         // 0 = read slot, 1 = write slot
    logic                  cmp_v_q, cmp_v_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic [AW-1:0]         caddr_q, caddr_d;
    logic                  pass_q, pass_d;
    logic [AW-1:0]         fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    logic                  mismatch;
    logic                  is_read;
    logic [DATA_WIDTH-1:0] read_bg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            ph_q        <= 1'b0;
            cmp_v_q     <= 1'b0;
            exp_q       <= '0;
            caddr_q     <= '0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ph_q        <= ph_d;
            cmp_v_q     <= cmp_v_d;
            exp_q       <= exp_d;
            caddr_q     <= caddr_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ph_d        = ph_q;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        mismatch    = cmp_v_q && (rdata_i != exp_q);
        is_read     = (state_q == S_M5) ||
                      ((state_q >= S_M1) && (state_q <= S_M4) && !ph_q);
        read_bg     = ((state_q == S_M2) || (state_q == S_M4)) ? C_ONES : '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_M0;
                    addr_d      = '0;
                    ph_d        = 1'b0;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                end
            end
            S_M0: begin
                if (addr_q == C_LAST) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AW'(1);
                end
            end
            S_M1, S_M2: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (addr_q == C_LAST) begin
                        state_d = state_q + 4'd1;
                        // M3 is the first descending element
                        addr_d  = (state_q == S_M2) ? C_LAST : '0;
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            S_M3, S_M4: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (addr_q == '0) begin
                        state_d = state_q + 4'd1;
                        addr_d  = C_LAST;
                    end else begin
                        addr_d = addr_q - AW'(1);
                    end
                end
            end
            S_M5: begin
                if (addr_q == '0) begin
                    state_d = S_CHECK;
                end else begin
                    addr_d = addr_q - AW'(1);
                end
            end
            S_CHECK: begin
                state_d = S_FIN;
                if (!mismatch) begin
                    pass_d = 1'b1;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // A failing compare overrides the march walk; the current access still goes out
        if (mismatch) begin
            state_d     = S_FIN;
            fail_addr_d = caddr_q;
            fail_data_d = rdata_i;
        end

        cmp_v_d = is_read && !mismatch;
        exp_d   = is_read ? read_bg : exp_q;
        caddr_d = is_read ? addr_q : caddr_q;
    end

    always_comb begin
        req_o       = (state_q >= S_M0) && (state_q <= S_M5);
        we_o        = (state_q == S_M0) ||
                      ((state_q >= S_M1) && (state_q <= S_M4) && ph_q);
        addr_o      = req_o ? addr_q : '0;
        wdata_o     = (we_o && ((state_q == S_M1) || (state_q == S_M3))) ? C_ONES : '0;
        be_o        = req_o ? {BW{1'b1}} : '0;
        busy_o      = (state_q != S_IDLE) && (state_q != S_FIN);
        done_o      = (state_q == S_FIN);
        pass_o      = pass_q;
        fail_addr_o = fail_addr_q;
        fail_data_o = fail_data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_march_bist.sv
`default_nettype none
// ============================================================================
// Module : tb_sram_march_bist
// Brief  : Scoreboard bench for sram_march_bist against an ideal SRAM model
// Rev    : 1.0
// ============================================================================
module tb_sram_march_bist;

    localparam int DW = 32;
    localparam int NW = 16;
    localparam int AW = 4;
    localparam int BW = 4;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, pass_o, req_o, we_o;
    logic [AW-1:0] fail_addr_o, addr_o;
    logic [DW-1:0] fail_data_o, wdata_o;
    logic [BW-1:0] be_o;
    logic [DW-1:0] rdata_i = '0;

    logic [DW-1:0] mem [NW];
    logic [DW-1:0] sa0 [NW];
    logic [DW-1:0] sa1 [NW];
    logic          fill_en = 1'b0;
    logic [DW-1:0] fill_val = '0;

    req_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    sram_march_bist #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .fail_addr_o (fail_addr_o),
        .fail_data_o (fail_data_o),
        .req_o       (req_o),
        .we_o        (we_o),
        .addr_o      (addr_o),
        .wdata_o     (wdata_o),
        .be_o        (be_o),
        .rdata_i     (rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Ideal SRAM; stuck-at faults are applied on the read path
    always @(posedge clk_i) begin
        if (fill_en) begin
            for (int i = 0; i < NW; i++) mem[i] <= fill_val;
        end else if (req_o && we_o) begin
            for (int b = 0; b < BW; b++)
                if (be_o[b]) mem[addr_o][8*b +: 8] <= wdata_o[8*b +: 8];
        end else if (req_o) begin
            rdata_i <= (mem[addr_o] | sa1[addr_o]) & ~sa0[addr_o];
        end
    end

    task automatic fill_mem(input logic [DW-1:0] v);
        fill_val = v;
        fill_en  = 1'b1;
        @(negedge clk_i);
        fill_en  = 1'b0;
    endtask

    task automatic build_march();
        exp_q.delete();
        for (int a = 0; a < NW; a++) exp_q.push_back('{1'b1, AW'(a), '0});
        for (int a = 0; a < NW; a++) begin
            exp_q.push_back('{1'b0, AW'(a), '0});
            exp_q.push_back('{1'b1, AW'(a), ONES});
        end
        for (int a = 0; a < NW; a++) begin
            exp_q.push_back('{1'b0, AW'(a), '0});
            exp_q.push_back('{1'b1, AW'(a), '0});
        end
        for (int a = NW - 1; a >= 0; a--) begin
            exp_q.push_back('{1'b0, AW'(a), '0});
            exp_q.push_back('{1'b1, AW'(a), ONES});
        end
        for (int a = NW - 1; a >= 0; a--) begin
            exp_q.push_back('{1'b0, AW'(a), '0});
            exp_q.push_back('{1'b1, AW'(a), '0});
        end
        for (int a = NW - 1; a >= 0; a--) exp_q.push_back('{1'b0, AW'(a), '0});
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, pass_o, req_o, we_o} !== 5'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: busy/done/pass/req/we=%b expected 00000",
                     {busy_o, done_o, pass_o, req_o, we_o});
        end
        n_checks++;
        if (fail_addr_o !== '0 || fail_data_o !== '0) begin
            n_errors++;
            $display("FAIL reset_fail_regs: addr=%h data=%h expected 0/0", fail_addr_o, fail_data_o);
        end
        n_checks++;
        if (addr_o !== '0 || wdata_o !== '0 || be_o !== '0) begin
            n_errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h be=%h expected 0", addr_o, wdata_o, be_o);
        end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    // Full fault-free run: request trace against the scoreboard, timing, final memory
    task automatic test_pass_and_order(input string name);
        req_t e;
        int   nbusy = 0, first_busy = -1, done_at = -1;
        fill_mem(32'hA5A5_A5A5);
        build_march();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 400 && done_at < 0; c++) begin
            if (busy_o) begin
                nbusy++;
                if (first_busy < 0) first_busy = c;
            end
            if (req_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL %s_extra_req: cycle %0d we=%b addr=%h expected none", name, c, we_o, addr_o);
                end else begin
                    e = exp_q.pop_front();
                    if (we_o !== e.we || addr_o !== e.addr || be_o !== '1 ||
                        (e.we && wdata_o !== e.wdata)) begin
                        n_errors++;
                        $display("FAIL %s_trace: cycle %0d got we=%b addr=%h wdata=%h be=%h expected we=%b addr=%h wdata=%h",
                                 name, c, we_o, addr_o, wdata_o, be_o, e.we, e.addr, e.wdata);
                    end
                end
            end
            if (done_o) done_at = c;
            else @(negedge clk_i);
        end
        n_checks++;
        if (done_at != 10*NW + 1) begin
            n_errors++;
            $display("FAIL %s_done_cycle: got %0d expected %0d", name, done_at, 10*NW + 1);
        end
        n_checks++;
        if (nbusy != 10*NW + 1 || first_busy != 0) begin
            n_errors++;
            $display("FAIL %s_busy: cycles=%0d first=%0d expected %0d/0", name, nbusy, first_busy, 10*NW + 1);
        end
        n_checks++;
        if (pass_o !== 1'b1 || busy_o !== 1'b0 || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s_result: pass=%b busy=%b left=%0d expected 1/0/0", name, pass_o, busy_o, exp_q.size());
        end
        @(negedge clk_i);
        n_checks++;
        if (done_o !== 1'b0 || pass_o !== 1'b1) begin
            n_errors++;
            $display("FAIL %s_done_pulse: done=%b pass=%b expected 0/1", name, done_o, pass_o);
        end
        for (int a = 0; a < NW; a++) begin
            n_checks++;
            if (mem[a] !== '0) begin
                n_errors++;
                $display("FAIL %s_mem[%0d]: got %h expected 00000000", name, a, mem[a]);
            end
        end
    endtask

    task automatic test_stuck_at(input string name, input int fa, input logic [DW-1:0] m0,
                                 input logic [DW-1:0] m1, input logic [DW-1:0] e_data,
                                 input int e_reqs);
        req_t e;
        int   nreq = 0, nbusy = 0, done_at = -1, late_req = 0;
        sa0[fa] = m0;
        sa1[fa] = m1;
        fill_mem('0);
        build_march();
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        n_checks++;
        if (pass_o !== 1'b0 || fail_addr_o !== '0 || fail_data_o !== '0) begin
            n_errors++;
            $display("FAIL %s_start_clear: pass=%b addr=%h data=%h expected 0", name, pass_o, fail_addr_o, fail_data_o);
        end
        for (int c = 0; c < 400 && done_at < 0; c++) begin
            if (busy_o) nbusy++;
            if (req_o) begin
                nreq++;
                e = exp_q.pop_front();
                n_checks++;
                if (we_o !== e.we || addr_o !== e.addr || (e.we && wdata_o !== e.wdata)) begin
                    n_errors++;
                    $display("FAIL %s_trace: cycle %0d got we=%b addr=%h expected we=%b addr=%h",
                             name, c, we_o, addr_o, e.we, e.addr);
                end
            end
            if (done_o) done_at = c;
            else @(negedge clk_i);
        end
        n_checks++;
        if (done_at < 0 || pass_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_done: done_at=%0d pass=%b expected done with pass 0", name, done_at, pass_o);
        end
        n_checks++;
        if (fail_addr_o !== AW'(fa) || fail_data_o !== e_data) begin
            n_errors++;
            $display("FAIL %s_capture: addr=%h data=%h expected %h/%h", name, fail_addr_o, fail_data_o, AW'(fa), e_data);
        end
        n_checks++;
        if (nreq != e_reqs || nbusy != e_reqs) begin
            n_errors++;
            $display("FAIL %s_stop: reqs=%0d busy=%0d expected %0d/%0d", name, nreq, nbusy, e_reqs, e_reqs);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (req_o) late_req++;
        end
        n_checks++;
        if (late_req != 0 || pass_o !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_after: reqs=%0d pass=%b expected 0/0", name, late_req, pass_o);
        end
        sa0[fa] = '0;
        sa1[fa] = '0;
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int  ndone = 0, nruns = 0, bstart = -1, last_done = -1;
        logic prev_busy = 1'b0, prev_done = 1'b0;
        fill_mem('0);
        start_i = 1'b1;
        @(negedge clk_i);
        for (int c = 0; c < 700 && ndone < 3; c++) begin
            if (busy_o && !prev_busy) begin
                bstart = c;
                if (ndone > 0) begin
                    n_checks++;
                    if (c - last_done != 2) begin
                        n_errors++;
                        $display("FAIL b2b_restart: gap=%0d expected 2", c - last_done);
                    end
                end
            end
            if (!busy_o && prev_busy) begin
                nruns++;
                n_checks++;
                if (c - bstart != 10*NW + 1) begin
                    n_errors++;
                    $display("FAIL b2b_busy_len: got %0d expected %0d", c - bstart, 10*NW + 1);
                end
            end
            if (done_o) begin
                ndone++;
                last_done = c;
                n_checks++;
                if (prev_done || pass_o !== 1'b1) begin
                    n_errors++;
                    $display("FAIL b2b_done: prev_done=%b pass=%b expected 0/1", prev_done, pass_o);
                end
                if (ndone == 3) start_i = 1'b0;
            end
            prev_busy = busy_o;
            prev_done = done_o;
            if (ndone < 3) @(negedge clk_i);
        end
        n_checks++;
        if (ndone != 3 || nruns != 3) begin
            n_errors++;
            $display("FAIL b2b_count: dones=%0d runs=%0d expected 3/3", ndone, nruns);
        end
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || req_o !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_stop: busy=%b req=%b expected 0/0", busy_o, req_o);
        end
    endtask

    task automatic test_reset_mid();
        int seen_done = 0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (done_o) seen_done++;
            @(negedge clk_i);
        end
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({busy_o, done_o, pass_o, req_o, we_o} !== 5'b0 || addr_o !== '0 ||
            wdata_o !== '0 || be_o !== '0 || fail_addr_o !== '0 || fail_data_o !== '0) begin
            n_errors++;
            $display("FAIL midreset_outputs: busy=%b done=%b pass=%b req=%b we=%b addr=%h wdata=%h be=%h expected all 0",
                     busy_o, done_o, pass_o, req_o, we_o, addr_o, wdata_o, be_o);
        end
        repeat (2) begin
            @(negedge clk_i);
            if (done_o) seen_done++;
        end
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            if (done_o || busy_o) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) begin
            n_errors++;
            $display("FAIL midreset_no_done: events=%0d expected 0", seen_done);
        end
        test_pass_and_order("after_reset");
    endtask

    initial begin
        for (int i = 0; i < NW; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
        test_reset();
        test_pass_and_order("pass");
        test_stuck_at("sa0_a5_b3", 5, 32'h0000_0008, '0, 32'hFFFF_FFF7, 60);
        test_stuck_at("sa1_a0_b0", 0, '0, 32'h0000_0001, 32'h0000_0001, 18);
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
